// File: rtl/tpu_command_feeder_pkg.sv
// Shared constants for the TPU command path: opcode values, command
// geometry, feeder state encoding and a saturating counter helper.
package tpu_command_feeder_pkg;

    localparam int TPU_CMD_WIDTH = 48;
    localparam int TPU_ARGS_MAX  = (TPU_CMD_WIDTH - 8) / 8;

    localparam logic [7:0] TPU_CLEARSCREEN = 8'h01;
    localparam logic [7:0] TPU_PRINT       = 8'h02;
    localparam logic [7:0] TPU_LOCATE      = 8'h03;
    localparam logic [7:0] TPU_SETATTR     = 8'h04;
    localparam logic [7:0] TPU_SETMASK     = 8'h05;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_ARGS,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT_DONE
    } feeder_state_t;

    // Increment an 8-bit error counter, sticking at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/tpu_opcode_decode.sv
// Combinational opcode decoder: tells a command source how many argument
// bytes follow an opcode and whether the opcode is known at all.
module tpu_opcode_decode
    import tpu_command_feeder_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [2:0] arg_count,
    output logic       valid
);

    // Map each known opcode to its argument byte count; unknown ones are invalid.
    always_comb begin
        arg_count = 3'd0;
        valid     = 1'b0;
        case (opcode)
            TPU_CLEARSCREEN: begin valid = 1'b1; arg_count = 3'd0; end
            TPU_PRINT:       begin valid = 1'b1; arg_count = 3'd1; end
            TPU_LOCATE:      begin valid = 1'b1; arg_count = 3'd2; end
            TPU_SETATTR:     begin valid = 1'b1; arg_count = 3'd2; end
            TPU_SETMASK:     begin valid = 1'b1; arg_count = 3'd3; end
            default:         begin valid = 1'b0; arg_count = 3'd0; end
        endcase
    end

endmodule

// File: rtl/tpu_command_feeder.sv
// Assembles TPU commands from a byte stream, strobes execute, and holds the
// command word stable until the TPU reports it is no longer busy.
module tpu_command_feeder
    import tpu_command_feeder_pkg::*;
#(
    parameter int BYTE_TIMEOUT  = 50000,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     busy,
    output logic                     execute,
    output logic [TPU_CMD_WIDTH-1:0] command,
    output logic                     sync_error,
    output logic [7:0]               error_count
);

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(BYTE_TIMEOUT - 1);

    feeder_state_t            state;
    logic [TIMEOUT_WIDTH-1:0] idle_count;
    logic [2:0]               arg_index;
    logic [2:0]               arg_total;
    logic [2:0]               op_args;
    logic                     op_valid;
    logic                     accept;
    logic [5:0]               arg_lsb;

    tpu_opcode_decode u_decode (
        .opcode    (in_data),
        .arg_count (op_args),
        .valid     (op_valid)
    );

    assign in_ready = reset && ((state == ST_OPCODE) || (state == ST_ARGS));
    assign accept   = in_valid && in_ready;
    assign arg_lsb  = {arg_index, 3'b000} + 6'd8;

    // Command assembly FSM with registered execute/sync_error strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_OPCODE;
            command     <= '0;
            execute     <= 1'b0;
            sync_error  <= 1'b0;
            error_count <= 8'd0;
            idle_count  <= '0;
            arg_index   <= 3'd0;
            arg_total   <= 3'd0;
        end else begin
            execute    <= 1'b0;
            sync_error <= 1'b0;
            case (state)
                ST_OPCODE: begin
                    if (accept) begin
                        if (op_valid) begin
                            command    <= {{(TPU_CMD_WIDTH-8){1'b0}}, in_data};
                            arg_index  <= 3'd0;
                            arg_total  <= op_args;
                            idle_count <= '0;
                            if (op_args == 3'd0) begin
                                state   <= ST_ISSUE;
                                execute <= 1'b1;
                            end else begin
                                state <= ST_ARGS;
                            end
                        end else begin
                            sync_error  <= 1'b1;
                            error_count <= sat_inc8(error_count);
                        end
                    end
                end
                ST_ARGS: begin
                    if (accept) begin
                        command[arg_lsb +: 8] <= in_data;
                        arg_index             <= arg_index + 3'd1;
                        idle_count            <= '0;
                        if ((arg_index + 3'd1) == arg_total) begin
                            state   <= ST_ISSUE;
                            execute <= 1'b1;
                        end
                    end else if (idle_count == TIMEOUT_LAST) begin
                        state       <= ST_OPCODE;
                        sync_error  <= 1'b1;
                        error_count <= sat_inc8(error_count);
                        idle_count  <= '0;
                    end else begin
                        idle_count <= idle_count + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_GUARD;
                end
                ST_GUARD: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!busy) begin
                        state <= ST_OPCODE;
                    end
                end
                default: begin
                    state <= ST_OPCODE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_command_feeder.sv
// Self-checking bench for tpu_command_feeder: directed scenarios plus a
// randomized byte stream, checked each cycle against a transaction-level model.
module tb_tpu_command_feeder;
    import tpu_command_feeder_pkg::*;

    localparam int BYTE_TIMEOUT  = 40;
    localparam int TIMEOUT_WIDTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        busy;
    logic        execute;
    logic [47:0] command;
    logic        sync_error;
    logic [7:0]  error_count;

    tpu_command_feeder #(
        .BYTE_TIMEOUT  (BYTE_TIMEOUT),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .execute     (execute),
        .command     (command),
        .sync_error  (sync_error),
        .error_count (error_count)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: the feeder is either idle, mid-command, or
    // engaged with the TPU from completion until busy is seen low.
    bit          engaged = 1'b0;
    int          engagedEdges = 0;
    bit          inProgress = 1'b0;
    int          argsNeeded = 0;
    int          argsGot = 0;
    int          gapEdges = 0;
    logic [47:0] mCmd = '0;
    bit          mExec = 1'b0;
    bit          mSync = 1'b0;
    int          mErrCount = 0;
    int          modelExecCount = 0;

    logic [7:0]  byteQ[$];
    int          validProb = 100;
    int          holdQ[$];
    int          holdMax = 12;
    int          busyLeft = 0;
    int          pendHold = -1;

    int          execSeen = 0;
    int          syncSeen = 0;
    logic [47:0] lastExecCmd = '0;

    logic [7:0]  validOps[5] = '{TPU_CLEARSCREEN, TPU_PRINT, TPU_LOCATE, TPU_SETATTR, TPU_SETMASK};

    task automatic checkOutput(input string tag, input logic [47:0] actual, input logic [47:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int modelArgs(input logic [7:0] op);
        case (op)
            TPU_CLEARSCREEN: return 0;
            TPU_PRINT:       return 1;
            TPU_LOCATE:      return 2;
            TPU_SETATTR:     return 2;
            TPU_SETMASK:     return 3;
            default:         return -1;
        endcase
    endfunction

    task automatic bumpErr();
        mSync = 1'b1;
        if (mErrCount < 255) mErrCount++;
    endtask

    task automatic completeCmd();
        mExec        = 1'b1;
        engaged      = 1'b1;
        engagedEdges = 0;
        inProgress   = 1'b0;
        modelExecCount++;
    endtask

    task automatic modelEdge();
        int n;
        mExec = 1'b0;
        mSync = 1'b0;
        if (!reset) begin
            engaged    = 1'b0;
            inProgress = 1'b0;
            gapEdges   = 0;
            mCmd       = '0;
            mErrCount  = 0;
        end else if (engaged) begin
            engagedEdges++;
            if (engagedEdges >= 3 && !busy) engaged = 1'b0;
        end else if (in_valid) begin
            if (byteQ.size() > 0) void'(byteQ.pop_front());
            if (!inProgress) begin
                n = modelArgs(in_data);
                if (n < 0) begin
                    bumpErr();
                end else begin
                    mCmd = {40'h0, in_data};
                    if (n == 0) begin
                        completeCmd();
                    end else begin
                        inProgress = 1'b1;
                        argsNeeded = n;
                        argsGot    = 0;
                        gapEdges   = 0;
                    end
                end
            end else begin
                mCmd[8 + 8*argsGot +: 8] = in_data;
                argsGot++;
                gapEdges = 0;
                if (argsGot == argsNeeded) completeCmd();
            end
        end else if (inProgress) begin
            gapEdges++;
            if (gapEdges == BYTE_TIMEOUT) begin
                inProgress = 1'b0;
                bumpErr();
            end
        end
    endtask

    task automatic tpuStep();
        if (!reset) begin
            busy     = 1'b0;
            busyLeft = 0;
            pendHold = -1;
        end else begin
            if (busyLeft > 0) begin
                busyLeft--;
                if (busyLeft == 0) busy = 1'b0;
            end
            if (pendHold >= 0) begin
                if (pendHold > 0) begin
                    busy     = 1'b1;
                    busyLeft = pendHold;
                end
                pendHold = -1;
            end
            if (execute === 1'b1) begin
                if (holdQ.size() > 0) pendHold = holdQ.pop_front();
                else pendHold = int'($urandom_range(holdMax, 0));
            end
        end
    endtask

    task automatic applyStimulus();
        if (byteQ.size() > 0 && int'($urandom_range(99, 0)) < validProb) begin
            in_valid = 1'b1;
            in_data  = byteQ[0];
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("in_ready", in_ready, reset && !engaged);
        checkOutput("execute", execute, mExec);
        checkOutput("sync_error", sync_error, mSync);
        checkOutput("error_count", error_count, mErrCount[7:0]);
        checkOutput("command", command, mCmd);
        if (execute === 1'b1) begin
            execSeen++;
            lastExecCmd = command;
        end
        if (sync_error === 1'b1) syncSeen++;
        tpuStep();
        applyStimulus();
    endtask

    task automatic runUntilIdle(input int maxCycles);
        int n = 0;
        while ((byteQ.size() > 0 || engaged || inProgress) && n < maxCycles) begin
            stepCycle();
            n++;
        end
        checkOutput("drain", (byteQ.size() == 0 && !engaged && !inProgress), 1);
    endtask

    task automatic pushByte(input logic [7:0] b);
        byteQ.push_back(b);
    endtask

    initial begin
        int n;
        logic [7:0] op;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        busy     = 1'b0;
        repeat (3) stepCycle();
        reset = 1'b1;
        applyStimulus();
        stepCycle();

        // LOCATE back-to-back, busy held across guard plus two cycles
        $display("[TB] LOCATE");
        holdQ.push_back(3);
        pushByte(TPU_LOCATE); pushByte(8'h0A); pushByte(8'h05);
        applyStimulus();
        runUntilIdle(200);
        checkOutput("locate_execs", execSeen, 1);
        checkOutput("locate_cmd", lastExecCmd, {24'h0, 8'h05, 8'h0A, TPU_LOCATE});

        // PRINT followed by CLEARSCREEN with a long clear busy
        $display("[TB] PRINT then CLEARSCREEN");
        holdQ.push_back(5); holdQ.push_back(6000);
        pushByte(TPU_PRINT); pushByte(8'h41); pushByte(TPU_CLEARSCREEN);
        applyStimulus();
        runUntilIdle(8000);
        checkOutput("clear_execs", execSeen, 3);
        checkOutput("clear_cmd", lastExecCmd, {40'h0, TPU_CLEARSCREEN});

        // SETMASK with alternating argument bytes
        $display("[TB] SETMASK");
        holdQ.push_back(2);
        pushByte(TPU_SETMASK); pushByte(8'hFF); pushByte(8'h00); pushByte(8'hFF);
        applyStimulus();
        runUntilIdle(200);
        checkOutput("setmask_execs", execSeen, 4);
        checkOutput("setmask_args", lastExecCmd[31:8], 24'hFF00FF);

        // Unknown opcode then a valid PRINT
        $display("[TB] unknown opcode");
        holdQ.push_back(0);
        pushByte(8'hEE); pushByte(TPU_PRINT); pushByte(8'h42);
        applyStimulus();
        runUntilIdle(200);
        checkOutput("bad_op_syncs", syncSeen, 1);
        checkOutput("bad_op_errcnt", error_count, 1);
        checkOutput("bad_op_execs", execSeen, 5);
        checkOutput("print_arg", lastExecCmd[15:8], 8'h42);

        // Partial LOCATE abandoned by inter-byte timeout, then a full LOCATE
        $display("[TB] timeout");
        pushByte(TPU_LOCATE); pushByte(8'h03);
        applyStimulus();
        runUntilIdle(BYTE_TIMEOUT + 20);
        checkOutput("timeout_syncs", syncSeen, 2);
        checkOutput("timeout_errcnt", error_count, 2);
        checkOutput("timeout_execs", execSeen, 5);
        holdQ.push_back(1);
        pushByte(TPU_LOCATE); pushByte(8'h11); pushByte(8'h22);
        applyStimulus();
        runUntilIdle(200);
        checkOutput("post_timeout_execs", execSeen, 6);
        checkOutput("post_timeout_cmd", lastExecCmd, {24'h0, 8'h22, 8'h11, TPU_LOCATE});

        // Gap of one less than the timeout must not discard the command
        $display("[TB] timeout boundary");
        holdQ.push_back(1);
        pushByte(TPU_LOCATE); pushByte(8'h01);
        applyStimulus();
        n = 0;
        while (byteQ.size() > 0 && n < 100) begin stepCycle(); n++; end
        repeat (BYTE_TIMEOUT - 1) stepCycle();
        pushByte(8'h02);
        validProb = 100;
        applyStimulus();
        runUntilIdle(200);
        checkOutput("boundary_syncs", syncSeen, 2);
        checkOutput("boundary_execs", execSeen, 7);
        checkOutput("boundary_cmd", lastExecCmd[23:0], {8'h02, 8'h01, TPU_LOCATE});

        // Randomized stream of valid and invalid commands
        $display("[TB] random stream");
        validProb = 70;
        for (int c = 0; c < 150; c++) begin
            if ($urandom_range(9, 0) == 0) begin
                do op = 8'($urandom); while (modelArgs(op) >= 0);
                pushByte(op);
            end else begin
                op = validOps[$urandom_range(4, 0)];
                pushByte(op);
                for (int a = 0; a < modelArgs(op); a++) pushByte(8'($urandom));
            end
        end
        applyStimulus();
        runUntilIdle(20000);
        checkOutput("random_execs", execSeen, modelExecCount);
        validProb = 100;

        // Reset while waiting on the TPU
        $display("[TB] reset in WAIT_DONE");
        holdQ.push_back(50);
        n = execSeen;
        pushByte(TPU_LOCATE); pushByte(8'h07); pushByte(8'h08);
        applyStimulus();
        for (int i = 0; i < 50 && execSeen == n; i++) stepCycle();
        repeat (4) stepCycle();
        reset = 1'b0;
        stepCycle();
        stepCycle();
        reset = 1'b1;
        stepCycle();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_command", command, 48'h0);
        checkOutput("rst_errcnt", error_count, 0);
        checkOutput("rst_execute", execute, 0);
        n = execSeen;
        repeat (60) stepCycle();
        checkOutput("rst_no_late_exec", execSeen, n);

        // Error counter saturation
        $display("[TB] saturation");
        for (int i = 0; i < 300; i++) pushByte(8'hEE);
        applyStimulus();
        runUntilIdle(1000);
        checkOutput("sat_errcnt", error_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/tpu_command_feeder.md
Name: tpu_command_feeder

Overview:
Initiator side of the TPU command interface. It assembles TPU commands from a byte stream (UART receiver or host bridge), presents them on `command`, and pulses `execute`. It holds `command` stable until the TPU drops `busy`, then accepts the next command. It sits between the serial receive path and the TPU.

Parameters:
BYTE_TIMEOUT, 50000, idle clock cycles allowed between argument bytes before a partial command is discarded.
TIMEOUT_WIDTH, 16, width of the inter-byte idle counter; must hold BYTE_TIMEOUT.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-low; logic resets on any posedge clk where reset == 0.
in_valid  input  1  in_data holds a byte.
in_data  input  8  command stream byte.
in_ready  output  1  feeder accepts a byte this cycle.
busy  input  1  TPU busy flag.
execute  output  1  one-cycle command strobe to the TPU.
command  output  48  command word to the TPU.
sync_error  output  1  one-cycle pulse on an unknown opcode or a timeout discard.
error_count  output  8  saturating count of sync_error pulses.

Behaviour:
- Reset values: execute=0, command=0, sync_error=0, error_count=0, state=OPCODE, idle counter=0, argument index=0. in_ready=0 while reset==0.
- in_ready is decoded from state: 1 in OPCODE and ARGS, 0 in all other states. A byte transfers on posedge when in_valid && in_ready.
- Byte layout: command[7:0]=opcode. Argument byte k (k=0..) goes to command[15+8k:8+8k]. command[47:8] is cleared when an opcode is accepted. Unused upper bits stay 0.
- Argument counts by opcode: TPU_CLEARSCREEN 0, TPU_PRINT 1, TPU_LOCATE 2 (x, y), TPU_SETATTR 2, TPU_SETMASK 3. Any other opcode is invalid.
- FSM:
  - OPCODE: on accept of a valid opcode, load command[7:0]. Go to ISSUE if the count is 0, otherwise ARGS.
  - OPCODE, invalid opcode: byte is dropped, sync_error=1 for one cycle, error_count++ (saturates at 255), stay in OPCODE.
  - ARGS: store each accepted byte and increment the index. When the last byte is accepted, go to ISSUE.
  - ARGS, timeout: the idle counter resets on every accepted byte and increments otherwise. When it reaches BYTE_TIMEOUT-1, discard the partial command, pulse sync_error, increment error_count and go to OPCODE. command[7:0] keeps its value; execute is not raised.
  - ISSUE: execute=1 for exactly this one cycle → GUARD.
  - GUARD: one cycle with busy ignored, to cover the TPU's registered busy rise → WAIT_DONE.
  - WAIT_DONE: when busy==0, go to OPCODE. command is held unchanged throughout ISSUE, GUARD and WAIT_DONE, because the TPU reads command[15:8] during execution.
- Command latency: execute rises one cycle after the final byte is accepted. The next byte can be accepted at the earliest 3 cycles after execute.
- A byte offered in ISSUE, GUARD or WAIT_DONE is back-pressured, never lost.
- Reset asserted mid-operation: immediate return to the reset state. A partial or outstanding command is abandoned and execute is never issued for it.
- busy is not checked in OPCODE or ARGS.

Decomposition:
- constant.vh holds TPU_* opcodes, TPU_ARGS_MAX=5 (derived from command width 48, i.e. (48-8)/8), and the state encodings.
- One natural sub-module: tpu_opcode_decode. It is combinational: opcode[7:0] → arg_count[2:0] plus valid, and is shared with any future command source.

Test Plan:
- LOCATE: bytes TPU_LOCATE, 0x0A, 0x05 back-to-back, busy held 1 for 2 cycles after GUARD → command[23:0]={0x05,0x0A,TPU_LOCATE}, upper bits 0. execute high exactly 1 cycle, 1 cycle after the last byte. in_ready low until busy==0.
- PRINT 0x41 then CLEARSCREEN, offered continuously; TPU model holds busy 6000 cycles for clear → second command issued only after the first busy falls. Clear command = {40'h0, TPU_CLEARSCREEN}. No byte lost.
- SETMASK 0xFF,0x00,0xFF → command[31:8]=0xFF00FF.
- Unknown opcode 0xEE, then valid PRINT 0x42 → sync_error 1 cycle, error_count=1, no execute for 0xEE. PRINT then executes with command[15:8]=0x42.
- TPU_LOCATE, 0x03, then silence BYTE_TIMEOUT cycles → sync_error, error_count+1, no execute. A following full LOCATE executes normally.
- reset driven to 0 during WAIT_DONE, released → execute=0, command=0, error_count=0, in_ready=1 the cycle after release.
- 300 invalid opcodes → error_count saturates at 255.
